// File: rtl/fb_line_fetch.sv
// Framebuffer row fetcher feeding the linebuffer write side, with vertical line replication.
// Define FB_LINE_FETCH_REG_EN to register lb_data (and delay lb_en) by one cycle.
module fb_line_fetch #(
    parameter int DATAW     = 4,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int SCALEW    = 6,
    parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT)
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              frame_sys,
    input  logic              line_sys,
    input  logic [SCALEW-1:0] scale,
    output logic [ADDRW-1:0]  fb_addr,
    input  logic [DATAW-1:0]  fb_data,
    output logic              lb_en,
    output logic [DATAW-1:0]  lb_data,
    output logic              busy,
    output logic              done
);

    localparam int ROWW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    localparam int IDXW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam logic [ROWW-1:0]  ROW_LAST = ROWW'(FB_HEIGHT-1);
    localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(FB_WIDTH);
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(FB_WIDTH-1);
    localparam logic [IDXW-1:0]  IDX_PRE  = IDXW'(FB_WIDTH-2);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q;
    logic [ROWW-1:0]   row_q, row_d;
    logic [SCALEW-1:0] cnt_q, cnt_d;
    logic [ADDRW-1:0]  base_q, base_d;
    logic              first_q, first_d;
    logic [IDXW-1:0]   idx_q;
    logic [ADDRW-1:0]  addr_q;
    logic              lb_en_q;
    logic              busy_q;
    logic              done_q;
    logic [SCALEW-1:0] scale_last;

    assign scale_last = (scale == '0) ? '0 : scale - 1'b1;

    // Row tracking: frame reset first, then the line step, so a coincident pair fetches row 0.
    always_comb begin
        row_d   = row_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        first_d = first_q;
        if (frame_sys) begin
            row_d   = '0;
            cnt_d   = '0;
            base_d  = '0;
            first_d = 1'b1;
        end
        if (line_sys) begin
            if (first_d) begin
                first_d = 1'b0;
            end else if (cnt_d == scale_last) begin
                cnt_d = '0;
                if (row_d != ROW_LAST) begin
                    row_d  = row_d + 1'b1;
                    base_d = base_d + ROW_STEP;
                end
            end else begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            first_q <= 1'b1;
            idx_q   <= '0;
            addr_q  <= '0;
            lb_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            first_q <= first_d;
            lb_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (line_sys) begin
                state_q <= FETCH;
                addr_q  <= base_d;
                idx_q   <= '0;
                lb_en_q <= 1'b1;
                busy_q  <= 1'b1;
            end else if (frame_sys) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (state_q == FETCH) begin
                if (idx_q == IDX_LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    addr_q <= addr_q + 1'b1;
                    idx_q  <= idx_q + 1'b1;
                    done_q <= (idx_q == IDX_PRE);
                end
            end
        end
    end

    assign fb_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef FB_LINE_FETCH_REG_EN
    logic             lb_en_p1_q;
    logic [DATAW-1:0] lb_data_q;

    // A restart or frame abort suppresses the delayed pulse of the burst it cancels.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            lb_en_p1_q <= 1'b0;
        end else begin
            lb_en_p1_q <= lb_en_q & ~frame_sys & ~line_sys;
        end
    end

    always_ff @(posedge clk_sys) begin
        lb_data_q <= fb_data;
    end

    assign lb_en   = lb_en_p1_q;
    assign lb_data = lb_data_q;
`else
    assign lb_en   = lb_en_q;
    assign lb_data = fb_data;
`endif

endmodule

// File: tb/tb_fb_line_fetch.sv
// Self-checking bench for fb_line_fetch: vector table, corner sequences and randomized run.
module tb_fb_line_fetch;

    localparam int DATAW     = 4;
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int SCALEW    = 6;
    localparam int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT);
`ifdef FB_LINE_FETCH_REG_EN
    localparam int EN_DLY = 2;
`else
    localparam int EN_DLY = 1;
`endif

    logic              clk_sys = 1'b0;
    logic              rst_sys;
    logic              frame_sys;
    logic              line_sys;
    logic [SCALEW-1:0] scale;
    logic [ADDRW-1:0]  fb_addr;
    logic [DATAW-1:0]  fb_data;
    logic              lb_en;
    logic [DATAW-1:0]  lb_data;
    logic              busy;
    logic              done;

    fb_line_fetch #(
        .DATAW(DATAW), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .SCALEW(SCALEW), .ADDRW(ADDRW)
    ) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .frame_sys(frame_sys), .line_sys(line_sys),
        .scale(scale), .fb_addr(fb_addr), .fb_data(fb_data), .lb_en(lb_en),
        .lb_data(lb_data), .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [DATAW-1:0] bram(input logic [ADDRW-1:0] a);
        return a[3:0] ^ a[11:8];
    endfunction

    always @(posedge clk_sys) fb_data <= bram(fb_addr);

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int done_cnt = 0;

    // Reference model: row/scale rules and burst position k (cycles since line_sys).
    int m_row, m_cnt, m_base, m_k, m_held;
    bit m_first, m_bv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit f, input bit l);
        int smax;
        if (r) begin
            m_row = 0; m_cnt = 0; m_first = 1; m_bv = 0; m_held = 0; m_k = 0; m_base = 0;
        end else begin
            if (f) begin
                m_row = 0; m_cnt = 0; m_first = 1; m_bv = 0;
            end
            if (l) begin
                smax = (scale == 0) ? 1 : int'(scale);
                if (m_first) m_first = 0;
                else if (m_cnt == smax - 1) begin
                    m_cnt = 0;
                    if (m_row < FB_HEIGHT - 1) m_row++;
                end else m_cnt = (m_cnt + 1) % (1 << SCALEW);
                m_base = m_row * FB_WIDTH;
                m_bv = 1;
                m_k = 0;
            end
            if (m_bv) begin
                m_k++;
                if (m_k <= FB_WIDTH) m_held = m_base + m_k - 1;
                if (m_k > FB_WIDTH + EN_DLY) m_bv = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit f, input bit l);
        rst_sys = r; frame_sys = f; line_sys = l;
        model(r, f, l);
        @(posedge clk_sys); #1;
        chk("busy", busy, m_bv && m_k <= FB_WIDTH);
        chk("done", done, m_bv && m_k == FB_WIDTH);
        chk("lb_en", lb_en, m_bv && m_k == EN_DLY);
        chk("fb_addr", fb_addr, m_held);
        if (m_bv && m_k > EN_DLY && m_k <= EN_DLY + FB_WIDTH)
            chk("lb_data", lb_data, bram(ADDRW'(m_base + m_k - EN_DLY - 1)));
        if (lb_en === 1'b1) en_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    typedef struct {
        bit   frame_pre;
        bit   same_cyc;
        int   scl;
        int   gap;
        int   exp_base;
    } vec_t;

    vec_t vecs[$];
    localparam int FULL = FB_WIDTH + 4;

    initial begin
        int base_seen;
        rst_sys = 1'b1; frame_sys = 1'b0; line_sys = 1'b0; scale = 6'd1;
        @(posedge clk_sys); #1;
        step(1, 0, 0);
        chk("reset_addr", fb_addr, 0);
        step(0, 0, 0);

        // Single scale=1 burst: exactly one lb_en, one done.
        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        en_cnt = 0; done_cnt = 0;
        step(0, 0, 1);
        for (int i = 0; i < FULL; i++) step(0, 0, 0);
        chk("single_en_cnt", en_cnt, 1);
        chk("single_done_cnt", done_cnt, 1);

        vecs.push_back('{1, 0, 3, FULL, 0});
        vecs.push_back('{0, 0, 3, FULL, 0});
        vecs.push_back('{0, 0, 3, FULL, 0});
        vecs.push_back('{0, 0, 3, FULL, 160});
        vecs.push_back('{0, 0, 3, FULL, 160});
        vecs.push_back('{1, 0, 0, FULL, 0});
        vecs.push_back('{0, 0, 0, FULL, 160});
        vecs.push_back('{0, 0, 0, FULL, 320});
        vecs.push_back('{1, 0, 1, FULL, 0});
        vecs.push_back('{0, 0, 1, 3, 160});
        vecs.push_back('{0, 0, 1, 3, 320});
        vecs.push_back('{0, 0, 1, 3, 480});
        vecs.push_back('{0, 0, 1, 3, 640});
        vecs.push_back('{0, 0, 1, 3, 800});
        vecs.push_back('{0, 0, 1, 3, 960});
        vecs.push_back('{0, 0, 1, 40, 1120});
        vecs.push_back('{0, 1, 2, FULL, 0});
        vecs.push_back('{0, 0, 2, FULL, 0});
        vecs.push_back('{0, 0, 2, FULL, 160});
        foreach (vecs[v]) begin
            scale = SCALEW'(vecs[v].scl);
            if (vecs[v].frame_pre) begin
                step(0, 1, 0);
                step(0, 0, 0);
            end
            step(0, vecs[v].same_cyc, 1);
            chk($sformatf("vec%0d_base", v), fb_addr, vecs[v].exp_base);
            for (int i = 1; i < vecs[v].gap; i++) step(0, 0, 0);
        end

        // Abort at word 50: no done from the first burst, restart at the next row.
        scale = 6'd1;
        step(0, 1, 0);
        step(0, 0, 0);
        en_cnt = 0; done_cnt = 0;
        step(0, 0, 1);
        for (int i = 0; i < 50; i++) step(0, 0, 0);
        chk("abort_word", fb_addr, 50);
        step(0, 0, 1);
        chk("abort_base", fb_addr, FB_WIDTH);
        for (int i = 0; i < FULL; i++) step(0, 0, 0);
        chk("abort_en_cnt", en_cnt, 2);
        chk("abort_done_cnt", done_cnt, 1);

        // Row saturation at the last framebuffer row.
        step(0, 1, 0);
        for (int n = 1; n <= FB_HEIGHT + 2; n++) begin
            step(0, 0, 1);
            base_seen = int'(fb_addr);
            if (n > FB_HEIGHT - 1) chk($sformatf("sat_base%0d", n), base_seen, (FB_HEIGHT - 1) * FB_WIDTH);
            for (int i = 0; i < ((n == FB_HEIGHT + 2) ? FULL : 3); i++) step(0, 0, 0);
        end
        chk("sat_last_addr", fb_addr, FB_WIDTH * FB_HEIGHT - 1);

        // Reset mid-burst.
        step(0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        done_cnt = 0;
        step(1, 0, 0);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < FULL; i++) step(0, 0, 0);
        chk("rst_mid_done_cnt", done_cnt, 0);

        // Randomized traffic; scale changes only together with a frame pulse.
        for (int c = 0; c < 4000; c++) begin
            bit r, f, l;
            r = ($urandom_range(0, 599) == 0);
            f = ($urandom_range(0, 249) == 0);
            l = ($urandom_range(0, 59) == 0) || ($urandom_range(0, 999) == 0 && f);
            if (f) scale = SCALEW'($urandom_range(0, 4));
            step(r, f, l);
        end
        for (int i = 0; i < FULL; i++) step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
